ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter; the sending end of the keyboard link whose receive side is ps2keyboard. Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) and returns the device ACK status. It runs on clock_50 next to the receiver and drives PS2_CLK/PS2_DAT open-drain through output enables. It is controlled from memctrl as a CPU-visible port.

Parameters:
INHIBIT_CYC, 6000, cycles the clock line is held low before the request (120 µs at 50 MHz)
WAIT_CYC, 750000, maximum cycles from request to the first device falling edge (15 ms)
PKT_CYC, 100000, maximum cycles from the first falling edge to the ACK edge (2 ms)
FILTER_LEN, 8, consecutive equal samples required to accept a PS2_CLK level change

Ports:
clock      in   1  50 MHz system clock (clock_50)
reset      in   1  synchronous, active-high reset
ps2_clk_i  in   1  raw PS2_CLK pin level
ps2_dat_i  in   1  raw PS2_DAT pin level
ps2_clk_oe out  1  1 = pull PS2_CLK low; 0 = release (Z)
ps2_dat_oe out  1  1 = pull PS2_DAT low; 0 = release (Z)
tx_data    in   8  byte to send, sampled on an accepted tx_start
tx_start   in   1  one-cycle request; ignored unless tx_busy=0
tx_busy    out  1  high from the accepted start until tx_done
tx_done    out  1  one-cycle completion pulse
tx_ack     out  1  valid on tx_done: 1 = device pulled DAT low on the ACK edge
tx_error   out  1  valid on tx_done: 1 = timeout or missing ACK

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_dat_oe=0, tx_busy=0, tx_done=0, tx_ack=0, tx_error=0. The FSM goes to IDLE and the timer and bit counter clear.
- Reset mid-transfer releases both lines on the next edge. No tx_done is produced.
- Input conditioning:
  - ps2_clk_i passes a 2-flop synchroniser, then a FILTER_LEN deglitch, giving clk_f.
  - ps2_dat_i passes a 2-flop synchroniser only, giving dat_s.
  - A falling edge (fall) is a one-cycle pulse when clk_f goes 1 to 0.
- FSM states: IDLE, INHIBIT, REQUEST, BITS, ACK, RELEASE, FINISH.
- IDLE: both lines released. On tx_start: latch tx_data into a shift register with odd parity, frame = {1 stop, parity, data[7:0]} shifted out LSB first. Set tx_busy=1 and go to INHIBIT.
- INHIBIT: clk_oe=1. After INHIBIT_CYC cycles, set dat_oe=1 (start bit 0) and go to REQUEST on the next cycle.
- REQUEST: clk_oe=0, dat_oe=1.
  - On fall: drive data bit0 (dat_oe = ~bit), set bit count to 1, go to BITS.
  - Timer reaching WAIT_CYC gives a timeout.
- BITS: on each fall, drive the next frame bit.
  - Edges 1–8 drive data bits; edge 9 drives parity; edge 10 drives stop (dat_oe=0).
  - The next fall after stop goes to ACK evaluation.
- ACK: on the 11th fall, sample dat_s. tx_ack = ~dat_s; tx_error = dat_s. Go to RELEASE.
- RELEASE: wait until clk_f=1 and dat_s=1, then go to FINISH.
- FINISH: tx_done=1 for one cycle, tx_busy=0, go to IDLE.
- Timeouts:
  - The timer counts from entry to REQUEST and restarts at the first fall.
  - Hitting WAIT_CYC in REQUEST, or PKT_CYC in BITS/ACK/RELEASE, forces both oe to 0, tx_ack=0, tx_error=1, and goes to FINISH.
- Latency: tx_done follows the release condition by exactly 2 cycles.
- Simultaneous tx_start and tx_done: the start is ignored because tx_busy is still 1 in that cycle.
- tx_ack and tx_error hold their values until the next accepted start, which clears both.
- Timer width is 20 bits. WAIT_CYC must fit; values above 2^20-1 are illegal.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state encoding
  - default cycle constants (INHIBIT_CYC, WAIT_CYC, PKT_CYC)
  - the odd-parity function, which is also usable by the receiver
- One sub-module, ps2_line_filter: synchroniser plus deglitch plus falling-edge pulse. It is written for reuse by the PS/2 receiver.

Test Plan:
- Send 0xED with a device model that ACKs. Expect:
  - CLK held low for 6000 cycles.
  - DAT bits seen at device rising edges: 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done with tx_ack=1 and tx_error=0.
- Send 0x07 (parity 0) and 0x00 (parity 1). Expect the parity bit to match on each frame and tx_ack=1 for both.
- Device never clocks. Expect tx_done exactly WAIT_CYC cycles after REQUEST entry plus 1, with tx_error=1, tx_ack=0, and both oe=0.
- Device clocks 11 edges but leaves DAT high at the ACK edge. Expect tx_ack=0 and tx_error=1.
- Pulse tx_start while busy, and add 3-cycle glitches on CLK during BITS. Expect the second byte not sent and no extra bit shifted.
- Assert reset at bit 5. Expect both oe=0 on the next cycle, tx_busy=0, and no tx_done pulse.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the keyboard receiver.
// Contents:
//   PS2_*_CYC   default cycle constants for a 50 MHz clock
//   TIMER_W     width of the transmitter timeout timer
//   ps2_tx_state_e  transmitter FSM encoding
//   odd_parity  parity bit that makes data plus parity carry an odd number of ones
package ps2_pkg;

    localparam int unsigned PS2_INHIBIT_CYC = 6000;    // 120 us clock inhibit
    localparam int unsigned PS2_WAIT_CYC    = 750000;  // 15 ms for the device to start clocking
    localparam int unsigned PS2_PKT_CYC     = 100000;  // 2 ms for the rest of the frame
    localparam int unsigned TIMER_W         = 20;      // every cycle constant must fit in this

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INHIBIT = 3'd1,
        REQUEST = 3'd2,
        BITS    = 3'd3,
        ACK     = 3'd4,
        RELEASE = 3'd5,
        FINISH  = 3'd6
    } ps2_tx_state_e;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning, shared by the host transmitter and the receiver.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   clk_raw       raw PS2_CLK pin level
//   dat_raw       raw PS2_DAT pin level
//   clk_f         PS2_CLK after a 2-flop synchroniser and a FILTER_LEN deglitch
//   dat_s         PS2_DAT after a 2-flop synchroniser
//   fall          one-cycle pulse in the first cycle clk_f reads 0 after 1
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clk_raw,
    input  logic dat_raw,
    output logic clk_f,
    output logic dat_s,
    output logic fall
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic [CW-1:0] cnt;

    // Both lines idle high, so the synchronisers and the filtered level
    // reset to 1 and no spurious edge appears after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            cnt      <= '0;
            clk_f    <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], clk_raw};
            dat_sync <= {dat_sync[0], dat_raw};
            fall     <= 1'b0;
            // cnt counts consecutive synchronised samples that disagree with
            // clk_f; any agreeing sample restarts the count, so a glitch
            // shorter than FILTER_LEN samples never reaches clk_f.
            if (clk_sync[1] == clk_f) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                clk_f <= clk_sync[1];
                fall  <= clk_f;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign dat_s = dat_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte and reports the
// device ACK. Lines are open-drain; an *_oe output of 1 pulls the line low.
// Ports:
//   clock, reset           50 MHz clock, synchronous active-high reset
//   ps2_clk_i, ps2_dat_i   raw pin levels
//   ps2_clk_oe, ps2_dat_oe 1 = pull line low, 0 = release
//   tx_data, tx_start      byte and its one-cycle request
//   tx_busy, tx_done       transfer in progress, one-cycle completion pulse
//   tx_ack, tx_error       status, valid on tx_done and held until the next start
//   fsm_state              current FSM state, for observation only
// Handshake: a tx_start is accepted only in a cycle where tx_busy=0; tx_data
// is captured in that cycle. tx_busy rises the next cycle and stays high
// through the tx_done cycle, so a start coinciding with tx_done is dropped.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = PS2_INHIBIT_CYC,  // at least 2
    parameter int unsigned WAIT_CYC    = PS2_WAIT_CYC,
    parameter int unsigned PKT_CYC     = PS2_PKT_CYC,
    parameter int unsigned FILTER_LEN  = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ps2_clk_i,
    input  logic          ps2_dat_i,
    output logic          ps2_clk_oe,
    output logic          ps2_dat_oe,
    input  logic [7:0]    tx_data,
    input  logic          tx_start,
    output logic          tx_busy,
    output logic          tx_done,
    output logic          tx_ack,
    output logic          tx_error,
    output ps2_tx_state_e fsm_state
);

    localparam logic [TIMER_W-1:0] INH_DAT   = TIMER_W'(INHIBIT_CYC - 2);
    localparam logic [TIMER_W-1:0] INH_LAST  = TIMER_W'(INHIBIT_CYC - 1);
    localparam logic [TIMER_W-1:0] WAIT_LAST = TIMER_W'(WAIT_CYC - 1);
    localparam logic [TIMER_W-1:0] PKT_LAST  = TIMER_W'(PKT_CYC - 1);

    logic          clk_f;
    logic          dat_s;
    logic          fall;
    ps2_tx_state_e state;
    logic [TIMER_W-1:0] timer;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;    // {stop, parity, data}, LSB goes out first

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clock  (clock),
        .reset  (reset),
        .clk_raw(ps2_clk_i),
        .dat_raw(ps2_dat_i),
        .clk_f  (clk_f),
        .dat_s  (dat_s),
        .fall   (fall)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_ack     <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (tx_start && !tx_busy) begin
                        shreg      <= {1'b1, odd_parity(tx_data), tx_data};
                        tx_ack     <= 1'b0;
                        tx_error   <= 1'b0;
                        tx_busy    <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        timer      <= '0;
                        bit_cnt    <= '0;
                        state      <= INHIBIT;
                    end else begin
                        // Busy is held through the tx_done cycle (spent here).
                        tx_busy <= 1'b0;
                    end
                end

                // Clock is held low for exactly INHIBIT_CYC cycles; data goes
                // low one cycle before the clock is released so the device
                // never sees a released clock with data still high.
                INHIBIT: begin
                    timer <= timer + 1'b1;
                    if (timer == INH_DAT) begin
                        ps2_dat_oe <= 1'b1;
                    end
                    if (timer == INH_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        timer      <= '0;
                        state      <= REQUEST;
                    end
                end

                // REQUEST lasts at most WAIT_CYC cycles before timing out.
                REQUEST: begin
                    if (fall) begin
                        ps2_dat_oe <= ~shreg[0];
                        shreg      <= shreg >> 1;
                        bit_cnt    <= 4'd1;
                        timer      <= '0;
                        state      <= BITS;
                    end else if (timer == WAIT_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_ack     <= 1'b0;
                        tx_error   <= 1'b1;
                        state      <= FINISH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                BITS, ACK, RELEASE: begin
                    if (timer == PKT_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_ack     <= 1'b0;
                        tx_error   <= 1'b1;
                        state      <= FINISH;
                    end else begin
                        timer <= timer + 1'b1;
                        if (state == BITS) begin
                            // bit_cnt counts falls seen so far; the tenth
                            // fall puts the stop bit (a release) on the line.
                            if (fall) begin
                                ps2_dat_oe <= ~shreg[0];
                                shreg      <= shreg >> 1;
                                bit_cnt    <= bit_cnt + 1'b1;
                                if (bit_cnt == 4'd9) begin
                                    state <= ACK;
                                end
                            end
                        end else if (state == ACK) begin
                            if (fall) begin
                                tx_ack   <= ~dat_s;
                                tx_error <= dat_s;
                                state    <= RELEASE;
                            end
                        end else begin
                            if (clk_f && dat_s) begin
                                state <= FINISH;
                            end
                        end
                    end
                end

                FINISH: begin
                    tx_done <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule
